// File: rtl/eer_rl_pkg.sv
// Shared EER-RL packet definitions: type codes, heartbeat word indices, parser states.
// HB_CHECKSUM_EN selects whether a heartbeat carries a trailing XOR checksum word.
package eer_rl_pkg;

    localparam int HB_WORD_W = 16;

    localparam logic [3:0] PKT_HB   = 4'h1;
    localparam logic [3:0] PKT_DATA = 4'h2;
    localparam logic [3:0] PKT_JOIN = 4'h3;
    localparam logic [3:0] PKT_ACK  = 4'h4;

    localparam logic [2:0] HB_W_HDR  = 3'd0;
    localparam logic [2:0] HB_W_SRC  = 3'd1;
    localparam logic [2:0] HB_W_HOPS = 3'd2;
    localparam logic [2:0] HB_W_CHID = 3'd3;
    localparam logic [2:0] HB_W_SLOT = 3'd4;
    localparam logic [2:0] HB_W_EMAX = 3'd5;
    localparam logic [2:0] HB_W_EMIN = 3'd6;
    localparam logic [2:0] HB_W_CSUM = 3'd7;

`ifdef HB_CHECKSUM_EN
    localparam logic [2:0] HB_W_LAST = HB_W_CSUM;
`else
    localparam logic [2:0] HB_W_LAST = HB_W_EMIN;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BODY   = 2'd1,
        ST_DROP   = 2'd2,
        ST_COMMIT = 2'd3
    } hb_state_e;

endpackage

// File: rtl/hb_csum_acc.sv
// Running XOR accumulator; clear and enable together load the first word directly.
module hb_csum_acc #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_acc
);

    logic [W-1:0] r_acc;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= i_en ? i_d : '0;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_d;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/hb_rx_parser.sv
// Heartbeat receive parser: shadows HB body words and commits them with a one-cycle en_MNI.
// Define HB_CHECKSUM_EN to require a trailing XOR checksum word (w7).
module hb_rx_parser
    import eer_rl_pkg::*;
#(
    parameter int         W       = HB_WORD_W,
    parameter logic [3:0] HB_TYPE = PKT_HB
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [W-1:0] rx_data,
    input  logic         rx_valid,
    input  logic         rx_sop,
    input  logic         rx_eop,
    output logic         rx_ready,
    output logic [W-1:0] src_id,
    output logic [W-1:0] hops,
    output logic [W-1:0] CH_ID,
    output logic [W-1:0] timeslot,
    output logic [W-1:0] e_max,
    output logic [W-1:0] e_min,
    output logic         en_MNI,
    output logic         pkt_err
);

    hb_state_e    r_state, w_state_nxt;
    logic [2:0]   r_cnt, w_cnt_nxt;
    logic [W-1:0] r_sh_src, r_sh_hops, r_sh_chid, r_sh_slot, r_sh_emax, r_sh_emin;
    logic [W-1:0] r_src, r_hops, r_chid, r_slot, r_emax, r_emin;
    logic         r_pkt_err;

    logic         w_xfer, w_is_hb, w_last, w_csum_ok;
    logic         w_hdr, w_err, w_commit, w_sh_we;
    logic [W-1:0] w_hops_inc, w_emin;

    assign w_xfer  = rx_valid & rx_ready;
    assign w_is_hb = (rx_data[W-1 -: 4] == HB_TYPE);
    assign w_last  = (r_cnt == HB_W_LAST);

`ifdef HB_CHECKSUM_EN
    logic [W-1:0] w_acc;

    hb_csum_acc #(.W(W)) u_csum (
        .clk   (clk),
        .nrst  (nrst),
        .i_clr (w_hdr),
        .i_en  ((w_hdr & w_is_hb) | w_sh_we),
        .i_d   (rx_data),
        .o_acc (w_acc)
    );

    assign w_csum_ok = (rx_data == w_acc);
`else
    assign w_csum_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pkt_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pkt_err <= w_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hdr       = 1'b0;
        w_err       = 1'b0;
        w_commit    = 1'b0;
        w_sh_we     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_xfer && rx_sop) w_hdr = 1'b1;
            end
            ST_BODY: begin
                if (w_xfer) begin
                    if (rx_sop) begin
                        w_err = 1'b1;
                        w_hdr = 1'b1;
                    end else if (w_last) begin
                        if (!rx_eop) begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_DROP;
                        end else if (!w_csum_ok) begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_commit    = 1'b1;
                            w_state_nxt = ST_COMMIT;
                        end
                    end else if (rx_eop) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_sh_we   = 1'b1;
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end
            ST_DROP: begin
                if (w_xfer && rx_eop) w_state_nxt = ST_IDLE;
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        // A header restarts parsing identically from IDLE or mid-body.
        if (w_hdr) begin
            if (w_is_hb) begin
                w_state_nxt = ST_BODY;
                w_cnt_nxt   = 3'd1;
            end else if (rx_eop) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = ST_DROP;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sh_src  <= '0;
            r_sh_hops <= '0;
            r_sh_chid <= '0;
            r_sh_slot <= '0;
            r_sh_emax <= '0;
            r_sh_emin <= '0;
        end else if (w_sh_we) begin
            case (r_cnt)
                HB_W_SRC:  r_sh_src  <= rx_data;
                HB_W_HOPS: r_sh_hops <= rx_data;
                HB_W_CHID: r_sh_chid <= rx_data;
                HB_W_SLOT: r_sh_slot <= rx_data;
                HB_W_EMAX: r_sh_emax <= rx_data;
                HB_W_EMIN: r_sh_emin <= rx_data;
                default: ;
            endcase
        end
    end

    // Without a checksum, e_min arrives on the committing word itself.
    assign w_emin     = (r_cnt == HB_W_EMIN) ? rx_data : r_sh_emin;
    assign w_hops_inc = (r_sh_hops == {W{1'b1}}) ? r_sh_hops : r_sh_hops + W'(1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_src  <= '0;
            r_hops <= '0;
            r_chid <= '0;
            r_slot <= '0;
            r_emax <= '0;
            r_emin <= '0;
        end else if (w_commit) begin
            r_src  <= r_sh_src;
            r_hops <= w_hops_inc;
            r_chid <= r_sh_chid;
            r_slot <= r_sh_slot;
            r_emax <= r_sh_emax;
            r_emin <= w_emin;
        end
    end

    assign rx_ready = (r_state != ST_COMMIT);
    assign en_MNI   = (r_state == ST_COMMIT);
    assign pkt_err  = r_pkt_err;
    assign src_id   = r_src;
    assign hops     = r_hops;
    assign CH_ID    = r_chid;
    assign timeslot = r_slot;
    assign e_max    = r_emax;
    assign e_min    = r_emin;

endmodule

// File: doc/hb_rx_parser.md
# hb_rx_parser

Receive-side heartbeat parser for the EER-RL node datapath. It accepts a stream of 16-bit words from the radio receive interface and validates heartbeat (HB) packets. It latches the hops, CH_ID, timeslot and energy-bound fields and issues a one-cycle `en_MNI` strobe to the node-information stage directly downstream, which consumes `hops`, `CH_ID`, `timeslot`, `e_max` and `e_min`.

## Interface
- `W`, 16: data/field width.
- `HB_TYPE`, 4'h1: header type code identifying a heartbeat packet.
- `clk`  in  1  clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  W  receive word.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_sop`  in  1  word is the first of a packet.
- `rx_eop`  in  1  word is the last of a packet.
- `rx_ready`  out  1  parser accepts a word this cycle.
- `src_id`  out  W  sender node ID of the last committed HB.
- `hops`  out  W  received hop count + 1, saturating at 16'hFFFF.
- `CH_ID`  out  W  cluster-head ID from the HB.
- `timeslot`  out  W  assigned TDMA slot.
- `e_max`  out  W  network max-energy bound.
- `e_min`  out  W  network min-energy bound.
- `en_MNI`  out  1  one-cycle strobe: new field set committed.
- `pkt_err`  out  1  one-cycle strobe: malformed or corrupt packet dropped.

## Operation
- A transfer occurs when `rx_valid` and `rx_ready` are both 1. Nothing advances without a transfer.
- HB packet word order:
  - w0: header, type in [15:12], [11:0] ignored.
  - w1: src_id.
  - w2: hops.
  - w3: CH_ID.
  - w4: timeslot.
  - w5: e_max.
  - w6: e_min.
  - w7: checksum, present only with checksum enabled.
- Last word index L is 6 without checksum and 7 with it.
- States: IDLE, BODY, DROP, COMMIT.
- IDLE: a word without `rx_sop` is discarded silently.
- IDLE, `rx_sop` and type == `HB_TYPE`: word count ← 1, go to BODY.
- IDLE, `rx_sop` and another type: go to DROP, no error. If `rx_eop` is also set on that word, stay in IDLE.
- BODY: words 1..6 load shadow registers. Output registers do not change until commit.
- BODY, transfer with `rx_sop`: pulse `pkt_err`, restart parsing with this word as a new header (same rules as IDLE).
- BODY, `rx_eop` before word L: pulse `pkt_err`, go to IDLE.
- BODY, word L without `rx_eop`: pulse `pkt_err`, go to DROP.
- BODY, word L with `rx_eop` and checks passing: copy shadows to outputs, with `hops` = min(w2+1, 16'hFFFF). Go to COMMIT.
- DROP: consume words until a transfer with `rx_eop`, then go to IDLE.
- COMMIT: `en_MNI`=1 and `rx_ready`=0 for exactly one cycle, then go to IDLE.
- `rx_ready` = 1 in every state except COMMIT.

## Timing
- Reset values:
  - all field outputs 0.
  - `en_MNI`=0, `pkt_err`=0.
  - `rx_ready`=1.
  - state IDLE.
- Commit latency: outputs update on the clock edge that accepts word L. `en_MNI` is high in the following cycle, with the outputs already stable.
- `pkt_err` is high in the cycle after the offending transfer.
- Output fields hold their values until the next commit; errors never disturb them.
- `nrst` asserted mid-packet: parse aborts, no `en_MNI`, all outputs return to reset values immediately.

## Configuration
- `HB_CHECKSUM_EN` defined:
  - L = 7.
  - w7 must equal the XOR of w0..w6.
  - On mismatch: pulse `pkt_err`, no commit, go to IDLE (w7 carries `rx_eop`).
- `HB_CHECKSUM_EN` undefined: L = 6, no checksum word, no XOR accumulator logic.

## Structure
- Shared package `eer_rl_pkg` holds:
  - the `HB_TYPE` code and other packet-type codes.
  - the word-index constants (`HB_W_SRC`…`HB_W_EMIN`, `HB_W_CSUM`).
  - the state enum.
- Sub-module `hb_csum_acc`: running XOR accumulator with clear and enable, instantiated only under `HB_CHECKSUM_EN`.

## Test plan
- Valid HB (src 0x0005, hops 0x0002, CH_ID 0x0009, slot 0x0003, e_max 0x0100, e_min 0x0010), sent back-to-back:
  - `hops`=0x0003, other fields as sent.
  - `en_MNI` one cycle after the eop word.
  - `rx_ready`=0 in that cycle.
- HB with hops 0xFFFF -> `hops`=0xFFFF, commit occurs.
- Non-HB header (type 4'h2) of 5 words, then a valid HB -> no `pkt_err`, a single `en_MNI` for the HB only.
- HB with `rx_eop` on w4 -> `pkt_err` pulse, fields unchanged. Then `rx_sop` on w3 of a following HB -> `pkt_err`, and the restarted HB commits.
- (`HB_CHECKSUM_EN`) w7 = correct XOR -> commit. Same packet with bit 0 of w7 flipped -> `pkt_err`, no `en_MNI`.
- `nrst` pulsed after w3 of an HB -> outputs 0, then a fresh HB commits normally.
